// File: rtl/cadc_decim.sv
`default_nettype none
// ============================================================================
// Module      : cadc_decim
// Description : Offset calibration, per-sample offset removal with saturation,
//               and 2**DEC_LOG2 decimation with a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module cadc_decim #(
    parameter int DW       = 8,
    parameter int DEC_LOG2 = 3,
    parameter int CAL_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DW-1:0]          dig_in,
    input  logic                   in_valid,
    input  logic                   cal_start,
    input  logic                   run_en,
    output logic [DW+DEC_LOG2-1:0] dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          offset,
    output logic                   cal_done,
    output logic                   ovf
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CAL  = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;

    localparam logic [DW-1:0] c_SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] c_SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [1:0]                state_q, state_d;
    logic [DW+CAL_LOG2-1:0]    cal_acc_q, cal_acc_d;
    logic [CAL_LOG2-1:0]       cal_cnt_q, cal_cnt_d;
    logic [DW+DEC_LOG2-1:0]    dec_acc_q, dec_acc_d;
    logic [DEC_LOG2-1:0]       dec_cnt_q, dec_cnt_d;
    logic [DW+DEC_LOG2-1:0]    dout_q, dout_d;
    logic                      out_valid_q, out_valid_d;
    logic [DW-1:0]             offset_q, offset_d;
    logic                      cal_done_q, cal_done_d;
    logic                      ovf_q, ovf_d;

    logic [DW+CAL_LOG2-1:0]    w_cal_sum;
    logic [DW:0]               w_diff;
    logic [DW-1:0]             w_corr;
    logic [DW+DEC_LOG2-1:0]    w_dec_sum;

    assign w_cal_sum = cal_acc_q + {{CAL_LOG2{dig_in[DW-1]}}, dig_in};
    assign w_diff    = {dig_in[DW-1], dig_in} - {offset_q[DW-1], offset_q};

    // The two top bits of the DW+1 difference disagree only when it is out of range.
    always_comb begin
        w_corr = w_diff[DW-1:0];
        if (w_diff[DW] != w_diff[DW-1]) begin
            w_corr = w_diff[DW] ? c_SAT_MIN : c_SAT_MAX;
        end
    end

    assign w_dec_sum = dec_acc_q + {{DEC_LOG2{w_corr[DW-1]}}, w_corr};

    always_comb begin
        state_d     = state_q;
        cal_acc_d   = cal_acc_q;
        cal_cnt_d   = cal_cnt_q;
        dec_acc_d   = dec_acc_q;
        dec_cnt_d   = dec_cnt_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        offset_d    = offset_q;
        cal_done_d  = 1'b0;
        ovf_d       = ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            c_IDLE: begin
                if (cal_start) begin
                    state_d   = c_CAL;
                    cal_acc_d = '0;
                    cal_cnt_d = '0;
                    ovf_d     = 1'b0;
                end else if (run_en) begin
                    state_d = c_RUN;
                end
            end
            c_CAL: begin
                if (in_valid) begin
                    if (cal_cnt_q == {CAL_LOG2{1'b1}}) begin
                        // Upper bits of the total are the floor of the mean.
                        offset_d   = w_cal_sum[DW+CAL_LOG2-1:CAL_LOG2];
                        cal_done_d = 1'b1;
                        ovf_d      = 1'b0;
                        cal_acc_d  = '0;
                        cal_cnt_d  = '0;
                        state_d    = run_en ? c_RUN : c_IDLE;
                    end else begin
                        cal_acc_d = w_cal_sum;
                        cal_cnt_d = cal_cnt_q + 1'b1;
                    end
                end
            end
            c_RUN: begin
                if (cal_start) begin
                    state_d   = c_CAL;
                    dec_acc_d = '0;
                    dec_cnt_d = '0;
                    cal_acc_d = '0;
                    cal_cnt_d = '0;
                    ovf_d     = 1'b0;
                end else if (!run_en) begin
                    state_d   = c_IDLE;
                    dec_acc_d = '0;
                    dec_cnt_d = '0;
                end else if (in_valid) begin
                    if (dec_cnt_q == {DEC_LOG2{1'b1}}) begin
                        dout_d      = w_dec_sum;
                        out_valid_d = 1'b1;
                        dec_acc_d   = '0;
                        dec_cnt_d   = '0;
                        if (out_valid_q && !out_ready) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        dec_acc_d = w_dec_sum;
                        dec_cnt_d = dec_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= c_IDLE;
            cal_acc_q   <= '0;
            cal_cnt_q   <= '0;
            dec_acc_q   <= '0;
            dec_cnt_q   <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            offset_q    <= '0;
            cal_done_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cal_acc_q   <= cal_acc_d;
            cal_cnt_q   <= cal_cnt_d;
            dec_acc_q   <= dec_acc_d;
            dec_cnt_q   <= dec_cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            offset_q    <= offset_d;
            cal_done_q  <= cal_done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign offset    = offset_q;
    assign cal_done  = cal_done_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cadc_decim.sv
`default_nettype none
// ============================================================================
// Module      : tb_cadc_decim
// Description : Directed self-checking bench for cadc_decim.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cadc_decim;

    localparam int DW       = 8;
    localparam int DEC_LOG2 = 3;
    localparam int CAL_LOG2 = 4;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [DW-1:0]          dig_in;
    logic                   in_valid;
    logic                   cal_start;
    logic                   run_en;
    logic [DW+DEC_LOG2-1:0] dout;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          offset;
    logic                   cal_done;
    logic                   ovf;

    int passed = 0;
    int total  = 0;
    int ovf_after_start;

    always #5 clk = ~clk;

    cadc_decim #(
        .DW       (DW),
        .DEC_LOG2 (DEC_LOG2),
        .CAL_LOG2 (CAL_LOG2)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .dig_in    (dig_in),
        .in_valid  (in_valid),
        .cal_start (cal_start),
        .run_en    (run_en),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .offset    (offset),
        .cal_done  (cal_done),
        .ovf       (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Full calibration: start request, then 16 valid samples alternating a/b.
    task automatic cal_run(input int a, input int b, input int exp_off, input string tag);
        int early;
        early     = 0;
        run_en    = 1'b0;
        in_valid  = 1'b0;
        cal_start = 1'b1;
        tick();
        ovf_after_start = int'(ovf);
        cal_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dig_in   = (i % 2 == 0) ? 8'(a) : 8'(b);
            in_valid = 1'b1;
            tick();
            if (i < 15) early += int'(cal_done);
        end
        chk({tag, "_early_done"}, early, 0);
        chk({tag, "_done"}, int'(cal_done), 1);
        chk({tag, "_offset"}, int'($signed(offset)), exp_off);
        in_valid = 1'b0;
        tick();
        chk({tag, "_done_pulse"}, int'(cal_done), 0);
    endtask

    task automatic enter_run();
        run_en   = 1'b1;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic samples(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            dig_in   = 8'(v);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        dig_in    = '0;
        in_valid  = 1'b0;
        cal_start = 1'b0;
        run_en    = 1'b0;
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            dig_in    = 8'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            cal_start = 1'($urandom_range(0, 1));
            run_en    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_dout", int'(dout), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_offset", int'(offset), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_cal_done", int'(cal_done), 0);

        rstn      = 1'b1;
        run_en    = 1'b0;
        cal_start = 1'b0;
        out_ready = 1'b0;
        dig_in    = 8'd50;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_offset", int'(offset), 0);
        chk("idle_cal_done", int'(cal_done), 0);
        chk("idle_dout", int'(dout), 0);

        cal_run(-5, -6, -6, "cal_round");
        cal_run(7, 7, 7, "cal_pos");
        cal_run(0, 0, 0, "cal_zero");

        // Continuous +3 with out_ready high.
        enter_run();
        out_ready = 1'b1;
        dig_in    = 8'd3;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            tick();
            if (i == 7) chk("dec_pre_valid", int'(out_valid), 0);
            if (i == 8) begin
                chk("dec_valid1", int'(out_valid), 1);
                chk("dec_dout1", int'($signed(dout)), 24);
            end
            if (i == 9) chk("dec_consumed", int'(out_valid), 0);
            if (i == 16) begin
                chk("dec_valid2", int'(out_valid), 1);
                chk("dec_dout2", int'($signed(dout)), 24);
            end
        end

        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            if (i == 13) chk("tog_pre_valid", int'(out_valid), 0);
            if (i == 14) begin
                chk("tog_valid", int'(out_valid), 1);
                chk("tog_dout", int'($signed(dout)), 24);
            end
            if (i == 15) chk("tog_consumed", int'(out_valid), 0);
        end
        in_valid = 1'b0;

        cal_run(-5, -5, -5, "cal_neg5");
        enter_run();
        samples(127, 8);
        chk("sat_hi_valid", int'(out_valid), 1);
        chk("sat_hi_dout", int'($signed(dout)), 1016);

        cal_run(5, 5, 5, "cal_pos5");
        enter_run();
        samples(-128, 8);
        chk("sat_lo_valid", int'(out_valid), 1);
        chk("sat_lo_dout", int'($signed(dout)), -1024);

        cal_run(0, 0, 0, "cal_bp");
        enter_run();
        out_ready = 1'b0;
        samples(1, 8);
        chk("bp_valid1", int'(out_valid), 1);
        chk("bp_dout1", int'($signed(dout)), 8);
        chk("bp_ovf1", int'(ovf), 0);
        samples(2, 7);
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_dout", int'($signed(dout)), 8);
        samples(2, 1);
        chk("bp_valid2", int'(out_valid), 1);
        chk("bp_dout2", int'($signed(dout)), 16);
        chk("bp_ovf2", int'(ovf), 1);
        out_ready = 1'b1;
        tick();
        chk("bp_drain_valid", int'(out_valid), 0);
        chk("bp_ovf_sticky", int'(ovf), 1);
        out_ready = 1'b0;
        cal_run(0, 0, 0, "cal_clr_ovf");
        chk("cal_start_clears_ovf", ovf_after_start, 0);

        // Reset asserted on the ninth calibration sample.
        cal_run(7, 7, 7, "cal_pre_rst");
        run_en    = 1'b0;
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        samples(20, 8);
        rstn     = 1'b0;
        dig_in   = 8'd20;
        in_valid = 1'b1;
        tick();
        chk("midrst_offset", int'(offset), 0);
        chk("midrst_cal_done", int'(cal_done), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        rstn     = 1'b1;
        in_valid = 1'b0;
        tick();
        cal_run(10, 10, 10, "cal_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cadc_decim.md
Name: cadc_decim

Overview:
- Post-processing stage directly downstream of the counter-ADC digital correction block.
- Consumes its signed 8-bit per-conversion code and removes a calibrated offset from each sample.
- Accumulates 2**DEC_LOG2 corrected samples into one decimated, higher-resolution output word.
- Delivers each word over a valid/ready handshake.

Parameters:
DW, 8, width of the signed input sample
DEC_LOG2, 3, log2 of the decimation ratio (samples per output word); legal range 1..8
CAL_LOG2, 4, log2 of the number of samples averaged during offset calibration; legal range 1..8

Ports:
clk  input  1  clock
rstn  input  1  active-low reset, synchronous to clk
dig_in  input  DW  signed conversion result from the upstream correction stage
in_valid  input  1  dig_in carries a new sample this cycle
cal_start  input  1  single-cycle request to run offset calibration
run_en  input  1  level; 1 = decimate in RUN, 0 = stay in or return to IDLE
dout  output  DW+DEC_LOG2  signed decimated sum
out_valid  output  1  dout holds an unconsumed result
out_ready  input  1  downstream accepts dout when out_valid=1
offset  output  DW  signed calibrated offset currently applied
cal_done  output  1  one-cycle pulse when calibration completes
ovf  output  1  sticky: an unconsumed result was overwritten

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rstn. All state updates on posedge clk.
- Values while rstn=0 (sampled at the edge):
  - state=IDLE, all accumulators and counters=0.
  - dout=0, out_valid=0, offset=0, cal_done=0, ovf=0.
- FSM states: IDLE, CAL, RUN.
  - IDLE: samples ignored. cal_start -> CAL. Otherwise, if run_en=1 -> RUN.
  - CAL: accumulates raw dig_in over 2**CAL_LOG2 accepted samples (in_valid=1) in a DW+CAL_LOG2-bit signed accumulator. cal_start and run_en are ignored.
    - On the cycle the last sample is accepted: offset <= acc_total >>> CAL_LOG2, an arithmetic shift that floors toward -inf.
    - Same cycle: cal_done pulses for 1 cycle on the following output, ovf cleared, and the CAL accumulator cleared.
    - Next state = RUN if run_en=1, else IDLE.
  - RUN: cal_start -> CAL, abandoning any partial decimation sum; a pending out_valid result is kept. run_en=0 -> IDLE, also discarding the partial sum.
- Per-sample correction in RUN: corr = saturate_DW(dig_in - offset).
  - Compute at DW+1 bits.
  - Clamp to [-(2**(DW-1)), 2**(DW-1)-1] (DW=8: -128..127).
- Decimation:
  - A DW+DEC_LOG2-bit signed accumulator sums corr over accepted samples.
  - A DEC_LOG2-bit counter wraps 2**DEC_LOG2-1 -> 0.
  - On the cycle the sample that completes the block is accepted: dout <= acc + corr, out_valid <= 1 on the next clock edge (1-cycle latency from the last sample), and the accumulator restarts at 0.
  - The sum cannot overflow its width.
- Output handshake:
  - dout and out_valid are held stable while out_valid=1 and out_ready=0.
  - out_valid=1 and out_ready=1 -> transfer. out_valid drops next cycle unless a new result completes the same cycle.
  - A new result completing with out_ready=1 in that cycle: no loss; the new result is presented next cycle with out_valid=1.
  - A new result completing while out_valid=1 and out_ready=0: dout overwritten with the new result, out_valid stays 1, ovf <= 1 (sticky).
  - ovf is cleared only by reset or by entering CAL.
- in_valid=0 cycles: no accumulation and no counter advance, in any state.
- Reset asserted mid-CAL or mid-RUN: everything returns to the reset values at that edge, and offset returns to 0.

Test Plan:
- Reset check: rstn=0 for 3 cycles with random inputs -> dout=0, out_valid=0, offset=0, ovf=0, cal_done=0. After release with run_en=0, cal_start=0, nothing changes.
- Calibration rounding: cal_start, then 16 valid samples alternating -5/-6 (sum -88) -> offset=-6 (floor of -5.5), cal_done pulses once.
  - Repeat with constant +7 -> offset=+7.
- Basic decimation: offset=0, run_en=1, dig_in=+3 continuous, out_ready=1 -> out_valid pulses every 8th cycle with dout=24, 1 cycle after the 8th sample.
  - With in_valid toggling 1/0 -> a result every 16 cycles, dout=24.
- Saturation and offset: offset=-5, dig_in=127 for 8 samples -> dout=1016. Offset=+5, dig_in=-128 -> dout=-1024.
- Backpressure: out_ready=0 over two block completions with dig_in=1 then dig_in=2.
  - Required: dout=8 held until the second completion, then dout=16, out_valid=1, ovf=1.
  - Raising out_ready for 1 cycle clears out_valid.
  - A subsequent cal_start clears ovf.
- Reset mid-operation: assert rstn=0 at sample 9 of a 16-sample calibration -> offset=0, state IDLE.
  - A new calibration then completes normally after exactly 16 valid samples.
